// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the operand
// forward-select encoding used by the ID/EX stage.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel.sv
// Combinational operand forwarding for one source register: the younger MEM
// producer beats WB, and register 0 is never forwarded.
module fwd_sel #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_result,
  output logic [1:0]      sel_o,
  output logic [XLEN-1:0] data_o
);
  import cpu_pkg::*;

  logic     mem_hit;
  logic     wb_hit;
  fwd_sel_e sel;

  always_comb begin
    mem_hit = mem_reg_we && (mem_rd != '0) && (mem_rd == rs);
    wb_hit  = wb_reg_we  && (wb_rd  != '0) && (wb_rd  == rs);
    sel     = FWD_REG;
    data_o  = reg_data;
    if (mem_hit) begin
      sel    = FWD_MEM;
      data_o = mem_result;
    end else if (wb_hit) begin
      sel    = FWD_WB;
      data_o = wb_result;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, WB bypass on
// capture, and load-use hazard detection toward the front end.
module id_ex_stage #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [XLEN-1:0]              id_pc,
  input  logic [XLEN-1:0]              id_rs1_data,
  input  logic [XLEN-1:0]              id_rs2_data,
  input  logic [XLEN-1:0]              id_imm,
  input  logic [RA_W-1:0]              id_rs1,
  input  logic [RA_W-1:0]              id_rs2,
  input  logic [RA_W-1:0]              id_rd,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [cpu_pkg::ALU_OP_W-1:0] id_alu_op,
  input  logic                         id_alu_src,
  input  logic                         id_reg_we,
  input  logic                         id_mem_re,
  input  logic                         id_mem_we,
  input  logic [RA_W-1:0]              mem_rd,
  input  logic                         mem_reg_we,
  input  logic [XLEN-1:0]              mem_result,
  input  logic [RA_W-1:0]              wb_rd,
  input  logic                         wb_reg_we,
  input  logic [XLEN-1:0]              wb_result,
  output logic                         load_use_stall,
  output logic                         ex_valid,
  output logic [XLEN-1:0]              ex_pc,
  output logic [XLEN-1:0]              ex_alu_a,
  output logic [XLEN-1:0]              ex_alu_b,
  output logic [cpu_pkg::ALU_OP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]              ex_store_data,
  output logic [RA_W-1:0]              ex_rd,
  output logic                         ex_reg_we,
  output logic                         ex_mem_re,
  output logic                         ex_mem_we
);
  import cpu_pkg::*;

  // Handshake: id_valid marks an instruction offered by decode; it is taken on
  // an edge with no flush, stall or load_use_stall. While load_use_stall is
  // high the front end must hold the same decode slot and re-present it.

  logic                valid_q,    valid_d;
  logic [XLEN-1:0]     pc_q,       pc_d;
  logic [XLEN-1:0]     rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]     rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]     imm_q,      imm_d;
  logic [RA_W-1:0]     rs1_q,      rs1_d;
  logic [RA_W-1:0]     rs2_q,      rs2_d;
  logic [RA_W-1:0]     rd_q,       rd_d;
  logic [ALU_OP_W-1:0] alu_op_q,   alu_op_d;
  logic                alu_src_q,  alu_src_d;
  logic                reg_we_q,   reg_we_d;
  logic                mem_re_q,   mem_re_d;
  logic                mem_we_q,   mem_we_d;

  logic [1:0]      rs1_sel, rs2_sel;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            wb_byp_rs1, wb_byp_rs2;
  logic            lu_hazard;

  fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs         (rs1_q),
    .reg_data   (rs1_data_q),
    .mem_rd     (mem_rd),
    .mem_reg_we (mem_reg_we),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_reg_we  (wb_reg_we),
    .wb_result  (wb_result),
    .sel_o      (rs1_sel),
    .data_o     (rs1_fwd)
  );

  fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs         (rs2_q),
    .reg_data   (rs2_data_q),
    .mem_rd     (mem_rd),
    .mem_reg_we (mem_reg_we),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_reg_we  (wb_reg_we),
    .wb_result  (wb_result),
    .sel_o      (rs2_sel),
    .data_o     (rs2_fwd)
  );

  always_comb begin
    lu_hazard = valid_q && mem_re_q && (rd_q != '0) && id_valid &&
                ((id_use_rs1 && (id_rs1 == rd_q)) ||
                 (id_use_rs2 && (id_rs2 == rd_q)));
    load_use_stall = lu_hazard && !flush;
    wb_byp_rs1 = wb_reg_we && (wb_rd != '0) && (wb_rd == id_rs1);
    wb_byp_rs2 = wb_reg_we && (wb_rd != '0) && (wb_rd == id_rs2);
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_op_d   = alu_op_q;
    alu_src_d  = alu_src_q;
    reg_we_d   = reg_we_q;
    mem_re_d   = mem_re_q;
    mem_we_d   = mem_we_q;
    if (flush || (!stall && load_use_stall)) begin
      valid_d   = 1'b0;
      alu_op_d  = '0;
      alu_src_d = 1'b0;
      reg_we_d  = 1'b0;
      mem_re_d  = 1'b0;
      mem_we_d  = 1'b0;
    end else if (stall) begin
      // Refresh held operands so a producer retiring mid-stall is not lost.
      if (rs1_sel != FWD_REG) rs1_data_d = rs1_fwd;
      if (rs2_sel != FWD_REG) rs2_data_d = rs2_fwd;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = wb_byp_rs1 ? wb_result : id_rs1_data;
      rs2_data_d = wb_byp_rs2 ? wb_result : id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      alu_op_d   = id_alu_op;
      alu_src_d  = id_alu_src;
      reg_we_d   = id_reg_we;
      mem_re_d   = id_mem_re;
      mem_we_d   = id_mem_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_op_q   <= '0;
      alu_src_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
      alu_src_q  <= alu_src_d;
      reg_we_q   <= reg_we_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_alu_a      = rs1_fwd;
  assign ex_alu_b      = alu_src_q ? imm_q : rs2_fwd;
  assign ex_alu_op     = alu_op_q;
  assign ex_store_data = rs2_fwd;
  assign ex_rd         = rd_q;
  assign ex_reg_we     = reg_we_q && valid_q;
  assign ex_mem_re     = mem_re_q && valid_q;
  assign ex_mem_we     = mem_we_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, r0, load-use bubble,
// flush, stall refresh and asynchronous reset.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall, flush, id_valid;
  logic [XLEN-1:0]     id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0]     id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_alu_src, id_reg_we, id_mem_re, id_mem_we;
  logic [RA_W-1:0]     mem_rd, wb_rd;
  logic                mem_reg_we, wb_reg_we;
  logic [XLEN-1:0]     mem_result, wb_result;
  logic                load_use_stall, ex_valid;
  logic [XLEN-1:0]     ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [RA_W-1:0]     ex_rd;
  logic                ex_reg_we, ex_mem_re, ex_mem_we;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_fwd();
    mem_rd = '0; mem_reg_we = 1'b0; mem_result = '0;
    wb_rd  = '0; wb_reg_we  = 1'b0; wb_result  = '0;
  endtask

  task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                          input logic [RA_W-1:0] rs1, input logic [XLEN-1:0] d1, input logic u1,
                          input logic [RA_W-1:0] rs2, input logic [XLEN-1:0] d2, input logic u2,
                          input logic [XLEN-1:0] imm, input logic src, input logic [RA_W-1:0] rd,
                          input logic [ALU_OP_W-1:0] op, input logic we, input logic re,
                          input logic sw);
    id_valid = v; id_pc = pc;
    id_rs1 = rs1; id_rs1_data = d1; id_use_rs1 = u1;
    id_rs2 = rs2; id_rs2_data = d2; id_use_rs2 = u2;
    id_imm = imm; id_alu_src = src; id_rd = rd; id_alu_op = op;
    id_reg_we = we; id_mem_re = re; id_mem_we = sw;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    idle_fwd();
    drive_id(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    check("rst_valid", ex_valid, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_alu_a", ex_alu_a, 0);
    check("rst_alu_b", ex_alu_b, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_ctrl", {ex_reg_we, ex_mem_re, ex_mem_we, load_use_stall}, 0);
    check("rst_rd_op", {ex_rd, ex_alu_op}, 0);
    rst_n = 1'b1;

    // Forwarding priority: ADD r8 = r5 + r6
    drive_id(1'b1, 32'h40, 5'd5, 32'h100, 1'b1, 5'd6, 32'h200, 1'b1, 32'h0, 1'b0, 5'd8,
             ALU_ADD, 1'b1, 1'b0, 1'b0);
    cyc();
    id_valid = 1'b0;
    check("add_valid", ex_valid, 1);
    check("add_pc", ex_pc, 32'h40);
    check("add_rd_we", {ex_rd, ex_reg_we}, {5'd8, 1'b1});
    check("add_a_reg", ex_alu_a, 32'h100);
    check("add_b_reg", ex_alu_b, 32'h200);
    mem_rd = 5'd5; mem_reg_we = 1'b1; mem_result = 32'h11;
    wb_rd  = 5'd5; wb_reg_we  = 1'b1; wb_result  = 32'h22;
    settle();
    check("fwd_mem_over_wb", ex_alu_a, 32'h11);
    mem_reg_we = 1'b0;
    settle();
    check("fwd_wb", ex_alu_a, 32'h22);
    idle_fwd();

    // ID-side WB bypass at capture
    drive_id(1'b1, 32'h44, 5'd10, 32'h1, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd11,
             ALU_OR, 1'b1, 1'b0, 1'b0);
    wb_rd = 5'd10; wb_reg_we = 1'b1; wb_result = 32'h3333;
    cyc();
    idle_fwd();
    settle();
    check("id_wb_bypass", ex_alu_a, 32'h3333);

    // Register 0 and store operand routing: SW r9 -> 7(r0)
    drive_id(1'b1, 32'h48, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 32'h7, 1'b1, 5'd0,
             ALU_ADD, 1'b0, 1'b0, 1'b1);
    cyc();
    id_valid = 1'b0;
    mem_rd = 5'd0; mem_reg_we = 1'b1; mem_result = 32'hFFFF_FFFF;
    wb_rd  = 5'd0; wb_reg_we  = 1'b1; wb_result  = 32'hFFFF_FFFF;
    settle();
    check("r0_no_fwd", ex_alu_a, 32'h0);
    check("sw_mem_we", ex_mem_we, 1);
    wb_rd = 5'd9; wb_result = 32'h77;
    settle();
    check("sw_alu_b_imm", ex_alu_b, 32'h7);
    check("sw_store_fwd", ex_store_data, 32'h77);
    idle_fwd();

    // Load-use: LW r3, 4(r1) then ADD r4 = r2 + r3
    drive_id(1'b1, 32'h50, 5'd1, 32'h1000, 1'b1, 5'd0, 32'h0, 1'b0, 32'h4, 1'b1, 5'd3,
             ALU_ADD, 1'b1, 1'b1, 1'b0);
    cyc();
    drive_id(1'b1, 32'h54, 5'd2, 32'h10, 1'b1, 5'd3, 32'hDEAD, 1'b1, 32'h0, 1'b0, 5'd4,
             ALU_ADD, 1'b1, 1'b0, 1'b0);
    settle();
    check("lu_raise", load_use_stall, 1);
    check("lu_lw_mem_re", ex_mem_re, 1);
    cyc();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", {ex_reg_we, ex_mem_re, ex_mem_we}, 0);
    check("lu_bubble_nostall", load_use_stall, 0);
    cyc();
    mem_rd = 5'd3; mem_reg_we = 1'b1; mem_result = 32'h5555;
    settle();
    check("lu_dep_valid", ex_valid, 1);
    check("lu_dep_pc", ex_pc, 32'h54);
    check("lu_dep_stall", load_use_stall, 0);
    check("lu_dep_b", ex_alu_b, 32'h5555);
    check("lu_dep_a", ex_alu_a, 32'h10);
    idle_fwd();

    // Flush: LW r3 in EX, dependent SUB in decode
    drive_id(1'b1, 32'h60, 5'd1, 32'h1000, 1'b1, 5'd0, 32'h0, 1'b0, 32'h8, 1'b1, 5'd3,
             ALU_ADD, 1'b1, 1'b1, 1'b0);
    cyc();
    drive_id(1'b1, 32'h64, 5'd3, 32'h0, 1'b1, 5'd6, 32'h0, 1'b1, 32'h0, 1'b0, 5'd7,
             ALU_SUB, 1'b1, 1'b0, 1'b1);
    settle();
    check("fl_hazard_seen", load_use_stall, 1);
    flush = 1'b1;
    settle();
    check("fl_no_stall", load_use_stall, 0);
    cyc();
    flush = 1'b0;
    id_valid = 1'b0;
    check("fl_valid", ex_valid, 0);
    check("fl_ctrl", {ex_reg_we, ex_mem_re, ex_mem_we}, 0);
    check("fl_alu_op", ex_alu_op, 0);

    // Stall refresh: ADD r9 = r7 + r0 with r7 retiring from WB in stall cycle 1
    drive_id(1'b1, 32'h80, 5'd7, 32'h0, 1'b1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 5'd9,
             ALU_ADD, 1'b1, 1'b0, 1'b0);
    cyc();
    stall = 1'b1;
    drive_id(1'b1, 32'h84, 5'd1, 32'h5, 1'b1, 5'd2, 32'h6, 1'b1, 32'h0, 1'b0, 5'd12,
             ALU_XOR, 1'b1, 1'b0, 1'b0);
    wb_rd = 5'd7; wb_reg_we = 1'b1; wb_result = 32'hABCD;
    settle();
    check("st_c1_a", ex_alu_a, 32'hABCD);
    cyc();
    idle_fwd();
    settle();
    check("st_c2_a", ex_alu_a, 32'hABCD);
    check("st_c2_pc", ex_pc, 32'h80);
    check("st_c2_valid", ex_valid, 1);
    cyc();
    check("st_c3_a", ex_alu_a, 32'hABCD);
    check("st_c3_op", ex_alu_op, ALU_ADD);
    cyc();
    stall = 1'b0;
    id_valid = 1'b0;
    settle();
    check("st_rel_a", ex_alu_a, 32'hABCD);
    check("st_rel_rd", ex_rd, 5'd9);

    // Async reset mid-stall
    drive_id(1'b1, 32'hC0, 5'd1, 32'h42, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd5,
             ALU_AND, 1'b1, 1'b0, 1'b0);
    cyc();
    stall = 1'b1;
    drive_id(1'b1, 32'hC4, 5'd5, 32'h0, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd6,
             ALU_ADD, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", ex_valid, 0);
    check("ar_pc_rd", {ex_pc, ex_rd}, 0);
    check("ar_alu_a", ex_alu_a, 0);
    check("ar_ctrl", {ex_reg_we, ex_mem_re, ex_mem_we, load_use_stall}, 0);
    rst_n = 1'b1;
    stall = 1'b0;
    drive_id(1'b1, 32'hD0, 5'd2, 32'h1234, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd13,
             ALU_SLT, 1'b1, 1'b0, 1'b0);
    cyc();
    id_valid = 1'b0;
    check("ar_cap_valid", ex_valid, 1);
    check("ar_cap_pc", ex_pc, 32'hD0);
    check("ar_cap_a", ex_alu_a, 32'h1234);
    check("ar_cap_op", ex_alu_op, ALU_SLT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
